// File: rtl/edge_pattern_gen.sv
// Programmable pulse-train generator: high_len cycles high, low_len cycles low, reps times,
// with registered rise/fall markers, busy/done status and synchronous abort.
module edge_pattern_gen #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned REP_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [CNT_W-1:0] high_len_i,
  input  logic [CNT_W-1:0] low_len_i,
  input  logic [REP_W-1:0] reps_i,
  input  logic             abort_i,
  output logic             wave_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [CNT_W-1:0] high_m1_q, high_m1_d;
  logic [CNT_W-1:0] low_m1_q, low_m1_d;
  logic             wave_q, wave_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             done_q, done_d;
  logic             accept;

  // Phase lengths are kept as (len-1) so a zero length behaves like one cycle.
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - CNT_W'(1);
  endfunction

  assign cmd_ready_o = (state_q == S_IDLE) & reset;
  assign accept      = cmd_valid_i & cmd_ready_o;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rep_d     = rep_q;
    high_m1_d = high_m1_q;
    low_m1_d  = low_m1_q;
    wave_d    = wave_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        wave_d = 1'b0;
        if (accept) begin
          high_m1_d = len_m1(high_len_i);
          low_m1_d  = len_m1(low_len_i);
          if (reps_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_HIGH;
            cnt_d   = len_m1(high_len_i);
            rep_d   = reps_i - REP_W'(1);
            wave_d  = 1'b1;
            rise_d  = 1'b1;
          end
        end
      end

      S_HIGH: begin
        if (abort_i) begin
          state_d = S_IDLE;
          wave_d  = 1'b0;
          fall_d  = wave_q;
        end else if (cnt_q == '0) begin
          state_d = S_LOW;
          cnt_d   = low_m1_q;
          wave_d  = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_LOW: begin
        if (abort_i) begin
          state_d = S_IDLE;
          wave_d  = 1'b0;
          fall_d  = wave_q;
        end else if (cnt_q == '0) begin
          // Repeat counter holds the number of periods still to start after this one.
          if (rep_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_HIGH;
            rep_d   = rep_q - REP_W'(1);
            cnt_d   = high_m1_q;
            wave_d  = 1'b1;
            rise_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        wave_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rep_q     <= '0;
      high_m1_q <= '0;
      low_m1_q  <= '0;
      wave_q    <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rep_q     <= rep_d;
      high_m1_q <= high_m1_d;
      low_m1_q  <= low_m1_d;
      wave_q    <= wave_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      done_q    <= done_d;
    end
  end

  assign wave_o = wave_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign done_o = done_q;
  assign busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_edge_pattern_gen.sv
// Scoreboard bench: a per-cycle reference of the pulse train feeds a queue that a monitor
// drains on the falling clock edge.
module tb_edge_pattern_gen;

  logic       clk;
  logic       reset;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [7:0] high_len_i;
  logic [7:0] low_len_i;
  logic [7:0] reps_i;
  logic       abort_i;
  logic       wave_o;
  logic       rise_o;
  logic       fall_o;
  logic       busy_o;
  logic       done_o;

  edge_pattern_gen #(.CNT_W(8), .REP_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .high_len_i (high_len_i),
    .low_len_i  (low_len_i),
    .reps_i     (reps_i),
    .abort_i    (abort_i),
    .wave_o     (wave_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic wave;
    logic rise;
    logic fall;
    logic busy;
    logic done;
    logic ready;
  } exp_t;

  exp_t exp_q[$];
  // Upcoming cycles of the reference: 1 = high, 0 = low, 2 = done pulse in idle.
  int   pend[$];
  logic prev_w;
  int   n_cmp;
  int   n_err;
  int   cyc;
  exp_t mon_e;

  task automatic chk(input string name, input logic act, input logic want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%b want=%b", name, cyc, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("wave",  wave_o,      mon_e.wave);
      chk("rise",  rise_o,      mon_e.rise);
      chk("fall",  fall_o,      mon_e.fall);
      chk("busy",  busy_o,      mon_e.busy);
      chk("done",  done_o,      mon_e.done);
      chk("ready", cmd_ready_o, mon_e.ready);
    end
  end

  // One clock cycle: drive inputs, record what the outputs must be in this cycle,
  // then advance the reference by the rules of the command protocol.
  task automatic step(input logic v, input logic [7:0] h, input logic [7:0] l,
                      input logic [7:0] r, input logic ab, input logic rst_n);
    exp_t e;
    int   cur;
    bit   busy_now;
    int   hh;
    int   ll;
    cmd_valid_i = v;
    high_len_i  = h;
    low_len_i   = l;
    reps_i      = r;
    abort_i     = ab;
    reset       = rst_n;
    cur      = (pend.size() > 0) ? pend[0] : -1;
    busy_now = (cur == 0) || (cur == 1);
    e.wave   = (cur == 1);
    e.busy   = busy_now;
    e.done   = (cur == 2);
    e.ready  = !busy_now && rst_n;
    e.rise   = e.wave && !prev_w;
    e.fall   = !e.wave && prev_w;
    exp_q.push_back(e);
    prev_w = e.wave;
    if (pend.size() > 0) void'(pend.pop_front());
    if (!rst_n) begin
      pend.delete();
      prev_w = 1'b0;
    end else if (ab && busy_now) begin
      pend.delete();
    end else if (v && e.ready) begin
      hh = (h == 0) ? 1 : int'(h);
      ll = (l == 0) ? 1 : int'(l);
      for (int k = 0; k < int'(r); k++) begin
        for (int i = 0; i < hh; i++) pend.push_back(1);
        for (int i = 0; i < ll; i++) pend.push_back(0);
      end
      pend.push_back(2);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'hA5, 8'h5A, 8'h33, 1'b0, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; prev_w = 1'b0;
    reset = 1'b0; cmd_valid_i = 1'b0; high_len_i = '0; low_len_i = '0;
    reps_i = '0; abort_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then release.
    step(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    step(1'b1, 8'd3, 8'd2, 8'd2, 1'b0, 1'b0);
    idle(2);

    // H=3, L=2, reps=2.
    step(1'b1, 8'd3, 8'd2, 8'd2, 1'b0, 1'b1);
    idle(13);

    // Empty command.
    step(1'b1, 8'd4, 8'd4, 8'd0, 1'b0, 1'b1);
    idle(3);

    // Zero lengths clamp to one cycle.
    step(1'b1, 8'd0, 8'd0, 8'd3, 1'b0, 1'b1);
    idle(9);

    // Abort in the second high cycle.
    step(1'b1, 8'd10, 8'd5, 8'd4, 1'b0, 1'b1);
    idle(1);
    step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1);
    idle(3);

    // Abort during a low phase, abort in idle together with a new command.
    step(1'b1, 8'd2, 8'd6, 8'd3, 1'b0, 1'b1);
    idle(4);
    step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1);
    step(1'b1, 8'd1, 8'd2, 8'd1, 1'b1, 1'b1);
    idle(5);

    // Reset in the low phase of a long command.
    step(1'b1, 8'd20, 8'd30, 8'd5, 1'b0, 1'b1);
    idle(25);
    step(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    idle(3);

    // Back-to-back: second command offered in the done cycle.
    step(1'b1, 8'd2, 8'd3, 8'd2, 1'b0, 1'b1);
    idle(10);
    step(1'b1, 8'd1, 8'd1, 8'd1, 1'b0, 1'b1);
    idle(4);

    // Counter extremes: maximum repeat count and maximum phase lengths.
    step(1'b1, 8'd1, 8'd1, 8'd255, 1'b0, 1'b1);
    idle(515);
    step(1'b1, 8'd255, 8'd255, 8'd40, 1'b0, 1'b1);
    idle(40 * 510 + 4);

    // Randomized traffic with sparse aborts and resets.
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] rh, rl, rr;
      rh = 8'($urandom_range(0, 6));
      rl = 8'($urandom_range(0, 6));
      rr = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 19) == 0) rh = 8'($urandom_range(0, 255));
      step($urandom_range(0, 2) == 0, rh, rl, rr,
           $urandom_range(0, 29) == 0, $urandom_range(0, 399) != 0);
    end
    idle(3);

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain cycle=%0d got=%0d want=0", cyc, exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
